// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared definitions for the BCD stopwatch: BCD digit width,
//               active-low seven-segment codes {g,f,e,d,c,b,a}, the run-state
//               encoding and a single-digit decimal increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   localparam int BCD_W = 4;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [0:0] {
      RUN_STOPPED = 1'b0,
      RUN_ACTIVE  = 1'b1
   } run_state_t;

   // Decimal increment of one digit: 9 rolls over to 0
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
      return (d == 4'd9) ? '0 : d + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational BCD nibble to active-low seven-segment decoder.
//               Codes 10..15 produce a blank pattern and valid_o = 0.
// Ports       : bcd_i   [3:0] BCD digit in
//               seg_o   [6:0] active-low {g,f,e,d,c,b,a}
//               valid_o       1 when bcd_i is a legal decimal digit
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   output logic [6:0]       seg_o,
   output logic             valid_o
);

   always_comb begin
      seg_o   = SEG_BLANK;
      valid_o = 1'b1;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: valid_o = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch
// Description : Multi-digit BCD stopwatch with multiplexed seven-segment scan.
//               A tick divider advances a decimal counter while running; a
//               free-running refresh divider steps the scanned digit.
// Ports       : clk        sole clock, rising edge
//               rst        synchronous active-high reset
//               start_stop single-cycle pulse, toggles run state
//               clr        single-cycle pulse, zeroes count and tick divider
//               seg [7:0]  active-low {dp,g,f,e,d,c,b,a}, registered
//               an  [N-1:0] active-low one-hot digit enable, registered
//               count_bcd  packed BCD count, digit 0 in [3:0]
//               running    current run state
//               wrap       one-cycle pulse on full-scale rollover
// Build macro : STOPWATCH_BLANK_EN - blank leading-zero digits above DP_DIGIT
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int TICK_DIV    = 1000000,
   parameter int REFRESH_DIV = 100000,
   parameter int DP_DIGIT    = 2
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_stop,
   input  logic                        clr,
   output logic [7:0]                  seg,
   output logic [NUM_DIGITS-1:0]       an,
   output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
   output logic                        running,
   output logic                        wrap
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int SCAN_W = $clog2(NUM_DIGITS);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);

   run_state_t                  run_state_q, run_state_d;
   logic [TICK_W-1:0]           tick_div_q,  tick_div_d;
   logic [BCD_W*NUM_DIGITS-1:0] count_q,     count_d;
   logic                        wrap_q,      wrap_d;
   logic [REF_W-1:0]            ref_q,       ref_d;
   logic [SCAN_W-1:0]           scan_q,      scan_d;
   logic [7:0]                  seg_q,       seg_d;
   logic [NUM_DIGITS-1:0]       an_q,        an_d;

   logic                        tick;
   logic [BCD_W*NUM_DIGITS-1:0] count_inc;
   logic                        full_wrap;
   logic [BCD_W-1:0]            scan_digit;
   logic [6:0]                  dec_seg;
   logic                        dec_valid;
   logic                        lead_blank;

   assign running   = (run_state_q == RUN_ACTIVE);
   assign tick      = running & (tick_div_q == TICK_LAST);
   assign count_bcd = count_q;
   assign wrap      = wrap_q;
   assign seg       = seg_q;
   assign an        = an_q;

   // Ripple decimal increment; the carry out of the top digit is full scale
   always_comb begin
      logic carry;
      carry     = tick;
      count_inc = count_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            count_inc[i*BCD_W +: BCD_W] = bcd_inc(count_q[i*BCD_W +: BCD_W]);
         end
         carry = carry & (count_q[i*BCD_W +: BCD_W] == 4'd9);
      end
      full_wrap = carry;
   end

`ifdef STOPWATCH_BLANK_EN
   // A digit is a leading zero when it and every digit above it are zero
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lead_blank = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (count_q[i*BCD_W +: BCD_W] == '0);
         if ((i > DP_DIGIT) && (i == int'(scan_q))) begin
            lead_blank = zero_above;
         end
      end
   end
`else
   assign lead_blank = 1'b0;
`endif

   assign scan_digit = count_q[scan_q*BCD_W +: BCD_W];

   seg7_decode u_dec (
      .bcd_i   (scan_digit),
      .seg_o   (dec_seg),
      .valid_o (dec_valid)
   );

   always_comb begin
      run_state_d = run_state_q;
      tick_div_d  = tick_div_q;
      count_d     = count_q;
      wrap_d      = 1'b0;
      ref_d       = ref_q;
      scan_d      = scan_q;
      seg_d       = 8'hFF;
      an_d        = ~(NUM_DIGITS'(1) << scan_q);

      if (start_stop) begin
         run_state_d = (run_state_q == RUN_ACTIVE) ? RUN_STOPPED : RUN_ACTIVE;
      end

      // clr wins over a coincident tick, which also suppresses wrap
      if (clr) begin
         tick_div_d = '0;
         count_d    = '0;
      end else begin
         if (running) begin
            tick_div_d = tick ? '0 : tick_div_q + TICK_W'(1);
         end
         count_d = count_inc;
         wrap_d  = full_wrap;
      end

      if (ref_q == REF_LAST) begin
         ref_d  = '0;
         scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
      end else begin
         ref_d  = ref_q + REF_W'(1);
      end

      if (dec_valid && !lead_blank) begin
         seg_d = {(int'(scan_q) != DP_DIGIT), dec_seg};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_state_q <= RUN_STOPPED;
         tick_div_q  <= '0;
         count_q     <= '0;
         wrap_q      <= 1'b0;
         ref_q       <= '0;
         scan_q      <= '0;
         seg_q       <= 8'hFF;
         an_q        <= '1;
      end else begin
         run_state_q <= run_state_d;
         tick_div_q  <= tick_div_d;
         count_q     <= count_d;
         wrap_q      <= wrap_d;
         ref_q       <= ref_d;
         scan_q      <= scan_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_stopwatch
// Description : Scoreboard bench for bcd_stopwatch. A 4-digit and a 2-digit
//               instance share stimulus; an integer-valued model predicts
//               every output each cycle, a negedge monitor compares.
// Build macro : STOPWATCH_BLANK_EN (must match the RTL build)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch;

   localparam int ND  = 4;
   localparam int ND2 = 2;
   localparam int TD  = 4;
   localparam int RD  = 2;
   localparam int DP  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_stop = 1'b0;
   logic clr = 1'b0;

   logic [7:0]  seg,  seg2;
   logic [3:0]  an;
   logic [1:0]  an2;
   logic [15:0] count_bcd;
   logic [7:0]  count2;
   logic        running, running2, wrap, wrap2;

   always #5 clk = ~clk;

   bcd_stopwatch #(.NUM_DIGITS(ND), .TICK_DIV(TD), .REFRESH_DIV(RD), .DP_DIGIT(DP)) dut (
      .clk(clk), .rst(rst), .start_stop(start_stop), .clr(clr),
      .seg(seg), .an(an), .count_bcd(count_bcd), .running(running), .wrap(wrap)
   );

   bcd_stopwatch #(.NUM_DIGITS(ND2), .TICK_DIV(TD), .REFRESH_DIV(RD), .DP_DIGIT(DP)) dut2 (
      .clk(clk), .rst(rst), .start_stop(start_stop), .clr(clr),
      .seg(seg2), .an(an2), .count_bcd(count2), .running(running2), .wrap(wrap2)
   );

   typedef struct {
      bit         run;
      int         div;
      int         cnt;
      bit         wrp;
      int         rfr;
      int         scan;
      logic [7:0] an;
      logic [7:0] seg;
   } mdl_t;

   typedef struct {
      logic [15:0] cnt4;
      logic        run4;
      logic        wrap4;
      logic [3:0]  an4;
      logic [7:0]  seg4;
      logic [7:0]  cnt2;
      logic        run2;
      logic        wrap2;
      logic [1:0]  an2;
      logic [7:0]  seg2;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   wrap2_seen = 0;

   function automatic int pow10(int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(int v, int n);
      logic [31:0] r = '0;
      int x = v;
      for (int i = 0; i < n; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Standard active-low glyphs {g,f,e,d,c,b,a}
   function automatic logic [6:0] glyph(int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // One clock of stopwatch behaviour on integer state
   function automatic mdl_t step(mdl_t s, int n, bit r, bit ss, bit cl);
      mdl_t o = s;
      bit   blank = 1'b0;
      int   d;
      if (r) begin
         o.run = 0; o.div = 0; o.cnt = 0; o.wrp = 0; o.rfr = 0; o.scan = 0;
         o.an = 8'hFF; o.seg = 8'hFF;
         return o;
      end
      o.an = 8'hFF;
      o.an[s.scan] = 1'b0;
      d = (s.cnt / pow10(s.scan)) % 10;
`ifdef STOPWATCH_BLANK_EN
      blank = (s.scan > DP) && (s.cnt < pow10(s.scan));
`endif
      o.seg = blank ? 8'hFF : {(s.scan != DP), glyph(d)};
      o.wrp = 1'b0;
      if (cl) begin
         o.cnt = 0;
         o.div = 0;
      end else if (s.run) begin
         if (s.div == TD - 1) begin
            o.div = 0;
            if (s.cnt == pow10(n) - 1) begin
               o.cnt = 0;
               o.wrp = 1'b1;
            end else begin
               o.cnt = s.cnt + 1;
            end
         end else begin
            o.div = s.div + 1;
         end
      end
      o.run = s.run ^ ss;
      if (s.rfr == RD - 1) begin
         o.rfr  = 0;
         o.scan = (s.scan + 1) % n;
      end else begin
         o.rfr = s.rfr + 1;
      end
      return o;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: samples the inputs at each edge and queues a prediction
   initial begin
      mdl_t        m4, m2;
      exp_t        e;
      logic [31:0] b;
      m4 = '{default: 0};
      m2 = '{default: 0};
      forever begin
         @(posedge clk);
         m4 = step(m4, ND,  rst, start_stop, clr);
         m2 = step(m2, ND2, rst, start_stop, clr);
         b = to_bcd(m4.cnt, ND);
         e.cnt4  = b[15:0];
         e.run4  = m4.run;
         e.wrap4 = m4.wrp;
         e.an4   = m4.an[3:0];
         e.seg4  = m4.seg;
         b = to_bcd(m2.cnt, ND2);
         e.cnt2  = b[7:0];
         e.run2  = m2.run;
         e.wrap2 = m2.wrp;
         e.an2   = m2.an[1:0];
         e.seg2  = m2.seg;
         sbq.push_back(e);
      end
   end

   // Monitor: pops one prediction per cycle and compares away from the edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wrap2 === 1'b1) wrap2_seen++;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("count4",   32'(count_bcd), 32'(e.cnt4));
            chk("running4", 32'(running),   32'(e.run4));
            chk("wrap4",    32'(wrap),      32'(e.wrap4));
            chk("an4",      32'(an),        32'(e.an4));
            chk("seg4",     32'(seg),       32'(e.seg4));
            chk("count2",   32'(count2),    32'(e.cnt2));
            chk("running2", 32'(running2),  32'(e.run2));
            chk("wrap2",    32'(wrap2),     32'(e.wrap2));
            chk("an2",      32'(an2),       32'(e.an2));
            chk("seg2",     32'(seg2),      32'(e.seg2));
         end
      end
   end

   task automatic pulse(bit ss, bit cl);
      start_stop = ss;
      clr        = cl;
      @(posedge clk);
      #1;
      start_stop = 1'b0;
      clr        = 1'b0;
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] scan_seq [8];
      scan_seq = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                   4'b1011, 4'b1011, 4'b0111, 4'b0111};

      // Reset
      cycles(3);
      chk("rst_an",      32'(an),        32'hF);
      chk("rst_seg",     32'(seg),       32'hFF);
      chk("rst_count",   32'(count_bcd), 32'h0);
      chk("rst_running", 32'(running),   32'h0);
      chk("rst_wrap",    32'(wrap),      32'h0);
      rst = 1'b0;

      // Counting
      pulse(1'b1, 1'b0);
      chk("start_running", 32'(running), 32'h1);
      cycles(40);
      chk("count_40", 32'(count_bcd), 32'h0010);

      // Pause and resume
      pulse(1'b0, 1'b1);
      cycles(8);
      chk("count_8", 32'(count_bcd), 32'h0002);
      pulse(1'b1, 1'b0);
      cycles(20);
      chk("paused_count",   32'(count_bcd), 32'h0002);
      chk("paused_running", 32'(running),   32'h0);
      pulse(1'b1, 1'b0);
      cycles(3);
      chk("resumed_count", 32'(count_bcd), 32'h0003);

      // clr coincident with a tick at 0009
      pulse(1'b0, 1'b1);
      cycles(39);
      chk("pre_clr_count", 32'(count_bcd), 32'h0009);
      pulse(1'b0, 1'b1);
      chk("clr_tick_count", 32'(count_bcd), 32'h0000);
      chk("clr_tick_run",   32'(running),   32'h1);

      // clr coincident with full-scale tick on the 2-digit instance
      cycles(399);
      chk("pre_clr_full", 32'(count2), 32'h99);
      pulse(1'b0, 1'b1);
      chk("clr_full_count", 32'(count2), 32'h00);
      chk("clr_full_wrap",  32'(wrap2),  32'h0);

      // Rollover of the 2-digit instance
      wrap2_seen = 0;
      cycles(400);
      chk("roll_count", 32'(count2), 32'h00);
      chk("roll_wrap",  32'(wrap2),  32'h1);
      cycles(1);
      chk("roll_wrap_end",   32'(wrap2),     32'h0);
      chk("roll_wrap_count", 32'(wrap2_seen), 32'h1);

      // rst overrides clr and start_stop mid-run
      rst = 1'b1; start_stop = 1'b1; clr = 1'b1;
      cycles(1);
      rst = 1'b0; start_stop = 1'b0; clr = 1'b0;
      chk("rst_ovr_running", 32'(running),   32'h0);
      chk("rst_ovr_count",   32'(count_bcd), 32'h0);
      chk("rst_ovr_an",      32'(an),        32'hF);

      // Scan order and decimal point after reset release
      for (int k = 0; k < 8; k++) begin
         cycles(1);
         chk("scan_an", 32'(an), 32'(scan_seq[k]));
         chk("scan_dp", 32'(seg[7]), (scan_seq[k] == 4'b1011) ? 32'h0 : 32'h1);
      end

      // Randomised control pulses
      for (int k = 0; k < 3000; k++) begin
         rst        = ($urandom_range(0, 299) == 0);
         start_stop = ($urandom_range(0, 39) == 0);
         clr        = ($urandom_range(0, 79) == 0);
         cycles(1);
      end
      rst = 1'b0; start_stop = 1'b0; clr = 1'b0;
      cycles(3);
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
